interval_timer_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit enable-gated up-counter datapath. It owns an internal up-counter and runs timed intervals of programmable length. Supports one-shot (N periods, then done) and periodic (free-running until stopped) modes. Exposes a start/busy/done handshake to a host FSM and a per-period tick to downstream logic.

---
 rtl/interval_timer_ctrl.sv | 107 ++++++++++
 tb/tb_interval_timer_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: one-shot (reps+1 periods) or periodic runs of limit+1 enabled cycles.
// Latency: busy/count one edge after start; tick/done are registered pulses with no input-to-output path.
module interval_timer_ctrl #(
  parameter int WIDTH  = 8,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              en,
  input  logic [WIDTH-1:0]  limit,
  input  logic [REPS_W-1:0] reps,
  input  logic              periodic,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic [WIDTH-1:0]  count,
  output logic [REPS_W-1:0] rep_left
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [REPS_W-1:0] rep_q,   rep_d;
  logic              mode_q,  mode_d;
  logic              tick_q,  tick_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
      rep_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    rep_d   = rep_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Config is captured only here, so mid-run changes on the inputs are invisible.
        if (start) begin
          limit_d = limit;
          rep_d   = reps;
          mode_d  = periodic;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          count_d = '0;
          rep_d   = '0;
          state_d = ST_IDLE;
        end else if (en) begin
          if (count_q != limit_q) begin
            count_d = count_q + 1'b1;
          end else begin
            count_d = '0;
            tick_d  = 1'b1;
            if (!mode_q) begin
              if (rep_q != '0) begin
                rep_d = rep_q - 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign tick     = tick_q;
  assign count    = count_q;
  assign rep_left = rep_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares after each edge.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, en, periodic;
  logic [7:0] limit;
  logic [3:0] reps;
  logic       busy, tick, done;
  logic [7:0] count;
  logic [3:0] rep_left;

  int n_vec = 0;
  int n_err = 0;

  logic [14:0] exp_q[$];
  string       name_q[$];

  interval_timer_ctrl #(.WIDTH(8), .REPS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .limit(limit), .reps(reps), .periodic(periodic),
    .busy(busy), .tick(tick), .done(done), .count(count), .rep_left(rep_left)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [14:0] want);
    logic [14:0] got;
    got = {busy, tick, done, count, rep_left};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got busy=%b tick=%b done=%b count=%0d rep_left=%0d, want busy=%b tick=%b done=%b count=%0d rep_left=%0d",
               name, got[14], got[13], got[12], got[11:4], got[3:0],
               want[14], want[13], want[12], want[11:4], want[3:0]);
    end
  endtask

  // Monitor: one expected vector per edge, checked 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        logic [14:0] w;
        string       nm;
        w  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, w);
      end
    end
  end

  task automatic vec(input string name, input logic s, input logic sp, input logic e,
                     input logic [7:0] lim, input logic [3:0] rp, input logic per,
                     input logic b, input logic t, input logic d,
                     input logic [7:0] c, input logic [3:0] rl);
    @(negedge clk);
    start = s; stop = sp; en = e; limit = lim; reps = rp; periodic = per;
    exp_q.push_back({b, t, d, c, rl});
    name_q.push_back(name);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; stop = 1'b0; en = 1'b1;
    limit = 8'd3; reps = 4'd1; periodic = 1'b0;

    // Reset held across edges with start/en high
    #23;
    compare("reset_hold", 15'd0);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;

    // One-shot: limit=3, reps=1
    vec("os_e0", 1, 0, 1, 3, 1, 0,  1, 0, 0, 0, 1);
    vec("os_e1", 0, 0, 1, 3, 1, 0,  1, 0, 0, 1, 1);
    vec("os_e2", 0, 0, 1, 3, 1, 0,  1, 0, 0, 2, 1);
    vec("os_e3", 0, 0, 1, 3, 1, 0,  1, 0, 0, 3, 1);
    vec("os_e4", 0, 0, 1, 3, 1, 0,  1, 1, 0, 0, 0);
    vec("os_e5", 0, 0, 1, 3, 1, 0,  1, 0, 0, 1, 0);
    vec("os_e6", 0, 0, 1, 3, 1, 0,  1, 0, 0, 2, 0);
    vec("os_e7", 0, 0, 1, 3, 1, 0,  1, 0, 0, 3, 0);
    vec("os_e8", 0, 0, 1, 3, 1, 0,  0, 1, 1, 0, 0);
    vec("os_e9", 0, 0, 1, 3, 1, 0,  0, 0, 0, 0, 0);

    // Enable gating: limit=2, reps=0, en 1,0,1,0,1
    vec("en_e0", 1, 0, 0, 2, 0, 0,  1, 0, 0, 0, 0);
    vec("en_e1", 0, 0, 1, 2, 0, 0,  1, 0, 0, 1, 0);
    vec("en_e2", 0, 0, 0, 2, 0, 0,  1, 0, 0, 1, 0);
    vec("en_e3", 0, 0, 1, 2, 0, 0,  1, 0, 0, 2, 0);
    vec("en_e4", 0, 0, 0, 2, 0, 0,  1, 0, 0, 2, 0);
    vec("en_e5", 0, 0, 1, 2, 0, 0,  0, 1, 1, 0, 0);
    vec("en_e6", 0, 0, 0, 2, 0, 0,  0, 0, 0, 0, 0);

    // Periodic limit=1 (reps latched but never consumed), then stop on a terminal cycle
    vec("per_e0", 1, 0, 1, 1, 3, 1,  1, 0, 0, 0, 3);
    for (int i = 1; i <= 10; i++) begin
      vec($sformatf("per_e%0d", i), 0, 0, 1, 1, 3, 1,
          1, (i % 2 == 0), 0, 8'(i % 2), 3);
    end
    vec("per_e11", 0, 0, 1, 1, 3, 1,  1, 0, 0, 1, 3);
    vec("per_stop", 0, 1, 1, 1, 3, 1,  0, 0, 0, 0, 0);
    vec("per_idle", 0, 0, 1, 1, 3, 1,  0, 0, 0, 0, 0);

    // Ignored requests: start/limit change mid-run, stop in IDLE, start+stop in IDLE
    vec("ign_e0", 1, 0, 1, 3, 0, 1,  1, 0, 0, 0, 0);
    vec("ign_e1", 1, 0, 1, 7, 0, 1,  1, 0, 0, 1, 0);
    vec("ign_e2", 0, 0, 1, 7, 0, 1,  1, 0, 0, 2, 0);
    vec("ign_e3", 1, 0, 1, 7, 0, 1,  1, 0, 0, 3, 0);
    vec("ign_e4", 0, 0, 1, 7, 0, 1,  1, 1, 0, 0, 0);
    vec("ign_e5", 0, 0, 1, 7, 0, 1,  1, 0, 0, 1, 0);
    vec("ign_e6", 0, 0, 1, 7, 0, 1,  1, 0, 0, 2, 0);
    vec("ign_e7", 0, 0, 1, 7, 0, 1,  1, 0, 0, 3, 0);
    vec("ign_e8", 0, 0, 1, 7, 0, 1,  1, 1, 0, 0, 0);
    vec("ign_stop", 0, 1, 1, 7, 0, 1,  0, 0, 0, 0, 0);
    vec("idle_stop", 0, 1, 1, 7, 0, 1,  0, 0, 0, 0, 0);
    vec("idle_quiet", 0, 0, 1, 7, 0, 1,  0, 0, 0, 0, 0);
    vec("ss_start", 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    vec("ss_term", 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0);
    vec("ss_idle", 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

    // Full-width period: limit=255, reps=0
    vec("max_e0", 1, 0, 1, 255, 0, 0,  1, 0, 0, 0, 0);
    for (int i = 1; i <= 255; i++) begin
      vec($sformatf("max_e%0d", i), 0, 0, 1, 255, 0, 0, 1, 0, 0, 8'(i), 0);
    end
    vec("max_e256", 0, 0, 1, 255, 0, 0,  0, 1, 1, 0, 0);
    vec("max_e257", 0, 0, 1, 255, 0, 0,  0, 0, 0, 0, 0);

    // limit=0, reps=15: sixteen back-to-back ticks
    vec("l0_e0", 1, 0, 1, 0, 15, 0,  1, 0, 0, 0, 15);
    for (int i = 1; i <= 15; i++) begin
      vec($sformatf("l0_e%0d", i), 0, 0, 1, 0, 15, 0, 1, 1, 0, 0, 4'(15 - i));
    end
    vec("l0_e16", 0, 0, 1, 0, 15, 0,  0, 1, 1, 0, 0);
    vec("l0_e17", 0, 0, 1, 0, 15, 0,  0, 0, 0, 0, 0);

    // Asynchronous reset right after a tick
    vec("ar_e0", 1, 0, 1, 1, 2, 1,  1, 0, 0, 0, 2);
    vec("ar_e1", 0, 0, 1, 1, 2, 1,  1, 0, 0, 1, 2);
    vec("ar_e2", 0, 0, 1, 1, 2, 1,  1, 1, 0, 0, 2);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 compare("reset_async", 15'd0);
    @(negedge clk);
    rst = 1'b1;
    vec("ar_after", 0, 0, 1, 1, 2, 1,  0, 0, 0, 0, 0);

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
